// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver.
// Raw ps_clk/ps_data are synchronized, ps_clk is glitch-filtered, and frames
// (start, 8 data bits LSB first, odd parity, stop) are assembled on filtered
// falling edges. Good bytes feed a scan-code decoder that tracks E0 and F0
// prefixes and emits one key event per non-prefix byte.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps_clk,
    input  logic       ps_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_break,
    output logic       key_ext,
    output logic       busy
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    // Filter toggles once the mismatch has persisted FILTER_LEN cycles.
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILTER_LEN - 1);
    // The timeout counter holds cycles elapsed since the last fall; testing
    // it one short of the limit lets the registered rx_err land exactly
    // TIMEOUT_CYCLES-1 cycles after that fall.
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 2);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Front end: synchronizers, filter and fall detection
    logic           sclk1_q, sclk1_d;
    logic           sclk2_q, sclk2_d;
    logic           sdat1_q, sdat1_d;
    logic           sdat2_q, sdat2_d;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           fall_q, fall_d;

    // Frame assembly
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TCW-1:0] to_q, to_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           rx_err_q, rx_err_d;
    logic           busy_q, busy_d;

    // Decoder
    logic           ext_pend_q, ext_pend_d;
    logic           brk_pend_q, brk_pend_d;
    logic [7:0]     key_code_q, key_code_d;
    logic           key_valid_q, key_valid_d;
    logic           key_break_q, key_break_d;
    logic           key_ext_q, key_ext_d;

    // Next-state for synchronizers and the ps_clk glitch filter
    always_comb begin
        sclk1_d = ps_clk;
        sclk2_d = sclk1_q;
        sdat1_d = ps_data;
        sdat2_d = sdat1_q;
        filt_d  = filt_q;
        fcnt_d  = '0;
        fall_d  = 1'b0;
        if (sclk2_q != filt_q) begin
            if (fcnt_q == FCNT_LAST) begin
                filt_d = ~filt_q;
                fcnt_d = '0;
                fall_d = filt_q;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end else begin
            fcnt_d = '0;
        end
    end

    // Front-end registers; idle-high lines reset to 1
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk1_q <= 1'b1;
            sclk2_q <= 1'b1;
            sdat1_q <= 1'b1;
            sdat2_q <= 1'b1;
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            fall_q  <= 1'b0;
        end else begin
            sclk1_q <= sclk1_d;
            sclk2_q <= sclk2_d;
            sdat1_q <= sdat1_d;
            sdat2_q <= sdat2_d;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            fall_q  <= fall_d;
        end
    end

    // Frame FSM next-state, frame check and timeout supervision
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        to_d       = to_q;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 3'd0;
                if (fall_q) begin
                    if (!sdat2_q) begin
                        state_d = ST_DATA;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_q) begin
                    shift_d = {sdat2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_q) begin
                    par_d   = sdat2_q;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_q) begin
                    state_d = ST_IDLE;
                    if (sdat2_q && odd_parity_ok(shift_q, par_q)) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fall always restarts the count, so it beats a coincident timeout.
        if (fall_q) begin
            to_d = TCW'(1);
        end else if (state_q == ST_IDLE) begin
            to_d = '0;
        end else if (to_q == TO_LAST) begin
            to_d       = '0;
            state_d    = ST_IDLE;
            rx_err_d   = 1'b1;
            rx_valid_d = 1'b0;
        end else begin
            to_d = to_q + TCW'(1);
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Frame FSM state and registered receiver outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            to_q       <= '0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_q       <= to_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            busy_q     <= busy_d;
        end
    end

    // Scan-code decoder: collect prefixes, emit one event per key byte
    always_comb begin
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        key_code_d  = key_code_q;
        key_break_d = key_break_q;
        key_ext_d   = key_ext_q;
        key_valid_d = 1'b0;
        if (rx_valid_q) begin
            if (rx_data_q == CODE_EXT) begin
                ext_pend_d = 1'b1;
            end else if (rx_data_q == CODE_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                key_code_d  = rx_data_q;
                key_break_d = brk_pend_q;
                key_ext_d   = ext_pend_q;
                key_valid_d = 1'b1;
                ext_pend_d  = 1'b0;
                brk_pend_d  = 1'b0;
            end
        end else if (rx_err_q) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else begin
            key_valid_d = 1'b0;
        end
    end

    // Decoder registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_code_q  <= 8'd0;
            key_valid_q <= 1'b0;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
        end else begin
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_break_q <= key_break_d;
            key_ext_q   <= key_ext_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_err    = rx_err_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_break = key_break_q;
    assign key_ext   = key_ext_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed PS/2 frames plus random traffic,
// compared against a frame/decoder model kept at the byte level.
module tb_ps2_rx;

    localparam int FLEN = 8;
    localparam int TOUT = 400;
    localparam int HALF = 40;
    // Raw ps_clk fall -> filtered fall: 2 sync + FLEN cycles.
    localparam int FALL_LAT = FLEN + 2;
    localparam int RXV_LAT  = FALL_LAT + 1;
    localparam int KEY_LAT  = FALL_LAT + 2;
    localparam int TO_LAT   = FALL_LAT + TOUT - 1;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps_clk = 1'b1;
    logic       ps_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_break;
    logic       key_ext;
    logic       busy;

    ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .resetn(resetn), .ps_clk(ps_clk), .ps_data(ps_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .key_code(key_code), .key_valid(key_valid), .key_break(key_break),
        .key_ext(key_ext), .busy(busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Observed events
    logic [7:0] mon_rx[$];
    int         mon_rx_cyc[$];
    int         mon_err_cyc[$];
    logic [9:0] mon_key[$];
    int         mon_key_cyc[$];
    int         both_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            mon_rx.push_back(rx_data);
            mon_rx_cyc.push_back(cyc);
        end
        if (rx_err) mon_err_cyc.push_back(cyc);
        if (key_valid) begin
            mon_key.push_back({key_code, key_break, key_ext});
            mon_key_cyc.push_back(cyc);
        end
        if (rx_valid && rx_err) both_cnt++;
    end

    // Reference model: expected events per frame plus decoder prefix state
    logic [7:0] exp_rx[$];
    logic [9:0] exp_key[$];
    int         exp_err = 0;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    logic [9:0] m_last = 10'd0;
    int         last_fall = 0;

    function automatic void model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            exp_rx.push_back(b);
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                m_last = {b, m_brk, m_ext};
                exp_key.push_back(m_last);
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    endfunction

    function automatic void clear_all();
        mon_rx.delete(); mon_rx_cyc.delete(); mon_err_cyc.delete();
        mon_key.delete(); mon_key_cyc.delete();
        exp_rx.delete(); exp_key.delete(); exp_err = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One device-driven bit: data set while clock high, then a low half
    task automatic clk_bit(input logic v);
        ps_data = v;
        tick(HALF);
        ps_clk = 1'b0;
        last_fall = cyc;
        tick(HALF);
        ps_clk = 1'b1;
    endtask

    task automatic check_frame();
        chk("rx_count", mon_rx.size(), exp_rx.size());
        for (int i = 0; i < mon_rx.size() && i < exp_rx.size(); i++)
            chk("rx_data", mon_rx[i], exp_rx[i]);
        if (mon_rx.size() > 0 && exp_rx.size() > 0)
            chk("rx_lat", mon_rx_cyc[0] - last_fall, RXV_LAT);
        chk("key_count", mon_key.size(), exp_key.size());
        for (int i = 0; i < mon_key.size() && i < exp_key.size(); i++)
            chk("key_fields", mon_key[i], exp_key[i]);
        if (mon_key.size() > 0 && exp_key.size() > 0)
            chk("key_lat", mon_key_cyc[0] - last_fall, KEY_LAT);
        chk("err_count", mon_err_cyc.size(), exp_err);
        chk("key_hold", {key_code, key_break, key_ext}, m_last);
        chk("busy_idle", busy, 1'b0);
        clear_all();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_bit);
        logic [10:0] bits;
        logic        par;
        par  = (~^b) ^ flip_par;
        bits = {stop_bit, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            clk_bit(bits[i]);
            if (i == 4) chk("busy_mid", busy, 1'b1);
        end
        ps_data = 1'b1;
        model_frame(b, !flip_par && stop_bit);
        tick(30);
        check_frame();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int         r;
        // Reset state
        tick(3);
        chk("rst_outs", {rx_data, rx_valid, rx_err, key_code, key_valid, key_break, key_ext, busy}, 20'd0);
        resetn = 1'b1;
        tick(20);

        // Plain make code
        send_frame(8'h1C, 1'b0, 1'b1);
        // Break sequence
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        // Extended break, then plain make
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        // Parity error drops pending break
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);

        // Short glitch while idle is ignored
        ps_clk = 1'b0;
        tick(3);
        ps_clk = 1'b1;
        tick(30);
        check_frame();

        // Truncated frame -> timeout
        clk_bit(1'b0);
        clk_bit(1'b1);
        clk_bit(1'b0);
        clk_bit(1'b1);
        ps_data = 1'b1;
        model_frame(8'h00, 1'b0);
        while (cyc < last_fall + TO_LAT - 2) tick(1);
        chk("busy_pre_to", busy, 1'b1);
        chk("err_pre_to", mon_err_cyc.size(), 0);
        while (cyc < last_fall + TO_LAT + 20) tick(1);
        chk("to_seen", mon_err_cyc.size(), 1);
        if (mon_err_cyc.size() > 0) chk("to_lat", mon_err_cyc[0] - last_fall, TO_LAT);
        check_frame();
        send_frame(8'h29, 1'b0, 1'b1);

        // Reset in the middle of the data bits
        clk_bit(1'b0);
        clk_bit(1'b1);
        clk_bit(1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_outs", {rx_data, rx_valid, rx_err, key_code, key_valid, key_break, key_ext, busy}, 20'd0);
        tick(5);
        chk("rst_mid_events", mon_rx.size() + mon_err_cyc.size() + mon_key.size(), 0);
        clear_all();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_last = 10'd0;
        ps_data = 1'b1;
        resetn = 1'b1;
        tick(20);
        send_frame(8'h5A, 1'b0, 1'b1);

        // Random traffic with prefixes, parity and stop errors
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) rb = 8'hE0;
            else if (r < 4) rb = 8'hF0;
            else rb = 8'($urandom);
            send_frame(rb, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0));
        end

        chk("valid_err_excl", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
